register_file: RTL

Architectural integer register file at the far end of the writeback interface: it accepts the writeback stage's data/id/write triple, stores 32 × 32-bit registers, and serves two registered read ports to decode. It also holds a pending-write scoreboard: decode marks a destination busy on issue, writeback clears it on commit. From these it raises a hazard flag that stalls decode. It sits between writeback (write side) and decode/execute (read side) of the tribe pipeline.

---
 rtl/register_file_pkg.sv | 13 +
 rtl/register_file_scoreboard.sv | 57 +++++
 rtl/register_file.sv | 81 ++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared register-file constants and id validity helper
package Regs_pkg;

  localparam int REG_ID_W  = 8;
  localparam int ARCH_REGS = 32;
  localparam int X0        = 0;

  // Register 0 and ids beyond the architectural range never hold state.
  function automatic logic reg_id_valid(input logic [REG_ID_W-1:0] id);
    return (id != REG_ID_W'(X0)) && (id < REG_ID_W'(ARCH_REGS));
  endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - pending-write busy bitmap and decode hazard detect
module register_file_scoreboard
  import Regs_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_in,
  input  logic                 clr_en_in,
  input  logic [REG_ID_W-1:0]  clr_id_in,
  input  logic                 set_en_in,
  input  logic [REG_ID_W-1:0]  set_id_in,
  input  logic [REG_ID_W-1:0]  rs1_id_in,
  input  logic [REG_ID_W-1:0]  rs2_id_in,
  output logic [ARCH_REGS-1:0] busy_mask_out,
  output logic                 hazard_out
);

  localparam int IDX_W = $clog2(ARCH_REGS);

  logic [ARCH_REGS-1:0] busy_nxt;
  logic                 rs1_hazard;
  logic                 rs2_hazard;

  // Clear is applied before set so an issue to a retiring id stays pending.
  always_comb begin
    busy_nxt = busy_mask_out;
    if (flush_in) begin
      busy_nxt = '0;
    end else begin
      if (clr_en_in && reg_id_valid(clr_id_in))
        busy_nxt[clr_id_in[IDX_W-1:0]] = 1'b0;
      if (set_en_in && reg_id_valid(set_id_in))
        busy_nxt[set_id_in[IDX_W-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_mask_out <= '0;
    else
      busy_mask_out <= busy_nxt;
  end

  // A register being written back this cycle is no longer a reason to stall.
  always_comb begin
    rs1_hazard = 1'b0;
    rs2_hazard = 1'b0;
    if (reg_id_valid(rs1_id_in))
      rs1_hazard = busy_mask_out[rs1_id_in[IDX_W-1:0]] &&
                   !(clr_en_in && (clr_id_in == rs1_id_in));
    if (reg_id_valid(rs2_id_in))
      rs2_hazard = busy_mask_out[rs2_id_in[IDX_W-1:0]] &&
                   !(clr_en_in && (clr_id_in == rs2_id_in));
    hazard_out = rs1_hazard || rs2_hazard;
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register array with bypassed registered read ports
module register_file
  import Regs_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          regs_data_in,
  input  logic [REG_ID_W-1:0]  regs_wr_id_in,
  input  logic                 regs_write_in,
  input  logic [REG_ID_W-1:0]  rs1_id_in,
  input  logic [REG_ID_W-1:0]  rs2_id_in,
  input  logic                 rd_en_in,
  input  logic                 issue_in,
  input  logic [REG_ID_W-1:0]  issue_rd_in,
  input  logic                 flush_in,
  output logic [31:0]          rs1_data_out,
  output logic [31:0]          rs2_data_out,
  output logic                 hazard_out,
  output logic [ARCH_REGS-1:0] busy_mask_out
);

  localparam int REGS  = ARCH_REGS;
  localparam int IDX_W = $clog2(REGS);

  logic [31:0] mem [REGS];
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  // Write-through: a same-cycle writeback to the read id wins over the array.
  function automatic logic [31:0] port_value(input logic [REG_ID_W-1:0] id,
                                             input logic [31:0]         entry);
    logic [31:0] val;
    val = '0;
    if (reg_id_valid(id)) begin
      if (regs_write_in && (regs_wr_id_in == id))
        val = regs_data_in;
      else
        val = entry;
    end
    return val;
  endfunction

  always_comb begin
    rs1_val = port_value(rs1_id_in, mem[rs1_id_in[IDX_W-1:0]]);
    rs2_val = port_value(rs2_id_in, mem[rs2_id_in[IDX_W-1:0]]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++)
        mem[i] <= '0;
    end else if (regs_write_in && reg_id_valid(regs_wr_id_in)) begin
      mem[regs_wr_id_in[IDX_W-1:0]] <= regs_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_data_out <= '0;
      rs2_data_out <= '0;
    end else if (rd_en_in) begin
      rs1_data_out <= rs1_val;
      rs2_data_out <= rs2_val;
    end
  end

  register_file_scoreboard u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .flush_in      (flush_in),
    .clr_en_in     (regs_write_in),
    .clr_id_in     (regs_wr_id_in),
    .set_en_in     (issue_in),
    .set_id_in     (issue_rd_in),
    .rs1_id_in     (rs1_id_in),
    .rs2_id_in     (rs2_id_in),
    .busy_mask_out (busy_mask_out),
    .hazard_out    (hazard_out)
  );

endmodule
